event_priority_encoder: RTL and testbench



---
 rtl/event_priority_encoder.sv | 127 ++++++++++++
 tb/tb_event_priority_encoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/event_priority_encoder.sv
// Registered N:log2(N) priority encoder with event capture, index lock and a
// valid/ready handshake; RR selects fixed (highest index) or round-robin priority.
module event_priority_encoder #(
  parameter int N  = 8,
  parameter int W  = $clog2(N),
  parameter int RR = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         clr,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         overflow
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [W-1:0]   lock_idx_q, lock_idx_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic           overflow_q, overflow_d;
  logic [W-1:0]   sel_s;
  logic [N-1:0]   served_s;
  logic           any_s;
  logic           accept_s;

  // Round-robin search starts at ptr and wraps at N-1, so results stay below N.
  function automatic logic [W-1:0] select_f(input logic [N-1:0] vec, input logic [W-1:0] start);
    logic [W-1:0] res;
    logic         found;
    int           idx;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (RR == 0) begin
        res = vec[i] ? W'(i) : res;
      end else begin
        idx = int'(start) + i;
        idx = (idx >= N) ? (idx - N) : idx;
        if (vec[idx] && !found) begin
          res   = W'(idx);
          found = 1'b1;
        end else begin
          found = found;
        end
      end
    end
    return res;
  endfunction

  // Presented index: the locked one in HOLD, otherwise the live selection.
  always_comb begin
    any_s = |pending_q;
    sel_s = select_f(pending_q, ptr_q);
    if (!any_s) begin
      out_idx = '0;
    end else if (state_q == HOLD) begin
      out_idx = lock_idx_q;
    end else begin
      out_idx = sel_s;
    end
  end

  assign out_valid = any_s;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

  // Next-state: capture, serve, overflow detection, lock and pointer update.
  always_comb begin
    accept_s = out_valid & out_ready;
    served_s = '0;
    if (accept_s) begin
      served_s[out_idx] = 1'b1;
    end else begin
      served_s = '0;
    end
    pending_d  = (pending_q & ~served_s) | req;
    overflow_d = |(req & pending_q & ~served_s);
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    ptr_d      = ptr_q;
    if (clr) begin
      pending_d  = '0;
      overflow_d = 1'b0;
      state_d    = IDLE;
      lock_idx_d = '0;
      ptr_d      = '0;
    end else if (accept_s) begin
      state_d = IDLE;
      if (int'(out_idx) == N - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = out_idx + 1'b1;
      end
    end else if (state_q == IDLE && any_s) begin
      state_d    = HOLD;
      lock_idx_d = sel_s;
    end else begin
      state_d = state_q;
    end
  end

  // Single register stage for the lock FSM and all held state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      lock_idx_q <= '0;
      ptr_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      lock_idx_q <= lock_idx_d;
      ptr_q      <= ptr_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_event_priority_encoder.sv
// Scoreboard bench: three encoder configurations (N8 fixed, N8 round-robin,
// N5 round-robin) share stimulus and are checked against a sticky-index model.
module tb_event_priority_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       clr;
  logic       rdy;

  logic       v0, v1, v2;
  logic [2:0] i0, i1, i2;
  logic [7:0] p0, p1;
  logic [4:0] p2;
  logic       o0, o1, o2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  event_priority_encoder #(.N(8), .RR(0)) u_fix8 (
    .clk(clk), .rst_n(rst_n), .req(req), .clr(clr), .out_ready(rdy),
    .out_valid(v0), .out_idx(i0), .pending(p0), .overflow(o0));
  event_priority_encoder #(.N(8), .RR(1)) u_rr8 (
    .clk(clk), .rst_n(rst_n), .req(req), .clr(clr), .out_ready(rdy),
    .out_valid(v1), .out_idx(i1), .pending(p1), .overflow(o1));
  event_priority_encoder #(.N(5), .RR(1)) u_rr5 (
    .clk(clk), .rst_n(rst_n), .req(req[4:0]), .clr(clr), .out_ready(rdy),
    .out_valid(v2), .out_idx(i2), .pending(p2), .overflow(o2));

  // Model: a pending set; an index once shown stays shown until it is accepted.
  typedef struct {
    logic [63:0] pend;
    bit          held;
    int          hidx;
    int          ptr;
  } mstate_t;

  typedef struct {
    int          k;
    logic        v;
    int          idx;
    logic [63:0] pend;
    logic        ovf;
  } exp_t;

  int      nn [3] = '{8, 8, 5};
  int      rrm[3] = '{0, 1, 1};
  mstate_t m  [3];
  exp_t    sbq[$];
  exp_t    pend_push[$];

  function automatic int pick(int k);
    int n = nn[k];
    if (rrm[k] == 0) begin
      for (int i = n - 1; i >= 0; i--) if (m[k].pend[i]) return i;
    end else begin
      for (int j = 0; j < n; j++) if (m[k].pend[(m[k].ptr + j) % n]) return (m[k].ptr + j) % n;
    end
    return 0;
  endfunction

  function automatic int shown(int k);
    if (m[k].pend == 64'd0) return 0;
    return m[k].held ? m[k].hidx : pick(k);
  endfunction

  function automatic exp_t model_edge(int k, logic [7:0] r, logic c, logic rd);
    exp_t        e;
    logic [63:0] rv, served, mask;
    logic        v, acc, ovf;
    int          idx;
    mask = (64'd1 << nn[k]) - 64'd1;
    rv   = {56'd0, r} & mask;
    v    = (m[k].pend != 64'd0);
    idx  = shown(k);
    acc  = v && rd;
    if (c) begin
      m[k].pend = 64'd0; m[k].held = 1'b0; m[k].hidx = 0; m[k].ptr = 0; ovf = 1'b0;
    end else begin
      served    = acc ? (64'd1 << idx) : 64'd0;
      ovf       = |(rv & m[k].pend & ~served);
      m[k].pend = (m[k].pend & ~served) | rv;
      m[k].held = v && !acc;
      m[k].hidx = idx;
      if (acc) m[k].ptr = (idx + 1) % nn[k];
    end
    e.k    = k;
    e.v    = (m[k].pend != 64'd0);
    e.idx  = shown(k);
    e.pend = m[k].pend;
    e.ovf  = ovf;
    return e;
  endfunction

  task automatic step(input logic [7:0] r, input logic c, input logic rd);
    req = r; clr = c; rdy = rd;
    for (int k = 0; k < 3; k++) pend_push.push_back(model_edge(k, r, c, rd));
    @(posedge clk);
    while (pend_push.size() > 0) sbq.push_back(pend_push.pop_front());
    #1;
  endtask

  // Monitor: pops expectations and compares against what the DUTs present.
  always @(negedge clk) begin
    exp_t        e;
    logic        av, ao;
    int          ai;
    logic [63:0] ap;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.k)
        0:       begin av = v0; ai = int'(i0); ap = {56'd0, p0}; ao = o0; end
        1:       begin av = v1; ai = int'(i1); ap = {56'd0, p1}; ao = o1; end
        default: begin av = v2; ai = int'(i2); ap = {59'd0, p2}; ao = o2; end
      endcase
      vectors++;
      if (av !== e.v || ai != e.idx || ap !== e.pend || ao !== e.ovf) begin
        miscompares++;
        $display("FAIL inst%0d t=%0t valid/idx/pending/overflow got %b/%0d/%h/%b want %b/%0d/%h/%b",
                 e.k, $time, av, ai, ap, ao, e.v, e.idx, e.pend, e.ovf);
      end
      if (e.k == 2) begin
        vectors++;
        if (v2 && i2 > 3'd4) begin
          miscompares++;
          $display("FAIL n5_range out_idx got %0d want <= 4", i2);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    vectors++;
    if ({v0, i0, p0, o0, v1, i1, p1, o1, v2, i2, p2, o2} !== '0) begin
      miscompares++;
      $display("FAIL %s outputs got %b/%0d/%h/%b %b/%0d/%h/%b %b/%0d/%h/%b want all 0",
               name, v0, i0, p0, o0, v1, i1, p1, o1, v2, i2, p2, o2);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m[k].pend = 64'd0; m[k].held = 1'b0; m[k].hidx = 0; m[k].ptr = 0;
    end
    rst_n = 1'b0; req = 8'h00; clr = 1'b0; rdy = 1'b0;
    #3;
    check_zero("reset");
    #4;
    rst_n = 1'b1;

    // Fixed-priority burst drains 7, 5, 2.
    step(8'hA4, 1'b0, 1'b1);
    repeat (4) step(8'h00, 1'b0, 1'b1);

    // Backpressure holds the locked index against a newer higher request.
    step(8'h02, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h80, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    repeat (3) step(8'h00, 1'b0, 1'b1);

    // Round-robin with held requests.
    repeat (7) step(8'h83, 1'b0, 1'b1);
    repeat (3) step(8'h00, 1'b0, 1'b1);

    // Overflow on a repeated pending bit, then re-arm in the accept cycle.
    step(8'h08, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h08, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h08, 1'b0, 1'b1);
    repeat (2) step(8'h00, 1'b0, 1'b1);

    // clr outranks simultaneous requests.
    step(8'h08, 1'b0, 1'b0);
    step(8'hFF, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);

    // N=5 alternation between bits 0 and 4.
    repeat (6) step(8'h11, 1'b0, 1'b1);
    repeat (3) step(8'h00, 1'b0, 1'b1);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
           ($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)));
    end
    repeat (10) step(8'h00, 1'b0, 1'b1);

    // Reset in the middle of a held handshake.
    step(8'h06, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    rdy = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mid_hold_reset");
    @(posedge clk);
    #1;
    check_zero("held_in_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
